// File: rtl/rot_addr_gen.sv
// Rotation DMA address generator: per row segment, one read burst, then one write burst (R=0) or per-pixel single-beat writes (R!=0).
// One command per cycle while I_DMA_READY is high; a stalled command holds stable because counters only move on acceptance.
module rot_addr_gen #(
  parameter int ADDR_W    = 32,
  parameter int DIM_W     = 16,
  parameter int BPP_LOG2  = 2,
  parameter int BURST_MAX = 16,
  parameter int LEN_W     = $clog2(BURST_MAX) + 1
) (
  input  logic              I_HCLK,
  input  logic              I_HRESET_N,
  input  logic              I_START,
  input  logic [DIM_W-1:0]  I_WIDTH,
  input  logic [DIM_W-1:0]  I_HEIGHT,
  input  logic [1:0]        I_DEGREES,
  input  logic              I_DIRECTION,
  input  logic [ADDR_W-1:0] I_SRC_BASE,
  input  logic [ADDR_W-1:0] I_DST_BASE,
  input  logic              I_DMA_READY,
  output logic              O_VALID,
  output logic [ADDR_W-1:0] O_ADDR,
  output logic [LEN_W-1:0]  O_LEN,
  output logic [2:0]        O_SIZE,
  output logic              O_WRITE,
  output logic              O_BUSY,
  output logic              O_DONE
);

  localparam int IW = 2 * DIM_W + 1;
  localparam int OW = IW + BPP_LOG2;

  typedef enum logic [1:0] {IDLE, RD_CMD, WR_CMD, DONE} state_t;

  state_t            state, state_nxt;
  logic [DIM_W-1:0]  w_q, h_q, y_q, x0_q, xi_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [1:0]        rot_q;

  logic [DIM_W-1:0]  rem, x, xp, yp, dw;
  logic              seg_last, xi_last, row_last;
  logic [LEN_W-1:0]  seg_n;
  logic [IW-1:0]     src_idx, dst_idx;
  logic [OW-1:0]     src_off, dst_off;

  assign rem      = w_q - x0_q;
  assign seg_last = 32'(rem) <= 32'(BURST_MAX);
  assign seg_n    = seg_last ? LEN_W'(rem) : LEN_W'(BURST_MAX);
  assign xi_last  = (32'(xi_q) + 32'd1) == 32'(seg_n);
  assign row_last = y_q == (h_q - DIM_W'(1));
  assign x        = x0_q + xi_q;

  // Destination coordinates; R=0 writes whole segments so x equals x0 there.
  always_comb begin
    xp = x;
    yp = y_q;
    dw = w_q;
    case (rot_q)
      2'd1: begin
        xp = h_q - DIM_W'(1) - y_q;
        yp = x;
        dw = h_q;
      end
      2'd2: begin
        xp = w_q - DIM_W'(1) - x;
        yp = h_q - DIM_W'(1) - y_q;
        dw = w_q;
      end
      2'd3: begin
        xp = y_q;
        yp = w_q - DIM_W'(1) - x;
        dw = h_q;
      end
      default: ;
    endcase
  end

  assign src_idx = IW'(y_q) * IW'(w_q) + IW'(x0_q);
  assign dst_idx = IW'(yp) * IW'(dw) + IW'(xp);
  assign src_off = OW'(src_idx) << BPP_LOG2;
  assign dst_off = OW'(dst_idx) << BPP_LOG2;
  assign O_SIZE  = 3'(BPP_LOG2);

  always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
    if (!I_HRESET_N) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    O_VALID   = 1'b0;
    O_ADDR    = '0;
    O_LEN     = '0;
    O_WRITE   = 1'b0;
    O_BUSY    = 1'b0;
    O_DONE    = 1'b0;
    case (state)
      IDLE: begin
        if (I_START)
          state_nxt = (I_WIDTH == '0 || I_HEIGHT == '0) ? DONE : RD_CMD;
      end
      RD_CMD: begin
        O_VALID = 1'b1;
        O_BUSY  = 1'b1;
        O_ADDR  = src_q + ADDR_W'(src_off);
        O_LEN   = seg_n;
        if (I_DMA_READY) state_nxt = WR_CMD;
      end
      WR_CMD: begin
        O_VALID = 1'b1;
        O_BUSY  = 1'b1;
        O_WRITE = 1'b1;
        O_ADDR  = dst_q + ADDR_W'(dst_off);
        O_LEN   = (rot_q == 2'd0) ? seg_n : LEN_W'(1);
        if (I_DMA_READY && (rot_q == 2'd0 || xi_last))
          state_nxt = (seg_last && row_last) ? DONE : RD_CMD;
      end
      DONE: begin
        O_BUSY    = 1'b1;
        O_DONE    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
    if (!I_HRESET_N) begin
      w_q   <= '0;
      h_q   <= '0;
      y_q   <= '0;
      x0_q  <= '0;
      xi_q  <= '0;
      src_q <= '0;
      dst_q <= '0;
      rot_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (I_START) begin
            w_q   <= I_WIDTH;
            h_q   <= I_HEIGHT;
            src_q <= I_SRC_BASE;
            dst_q <= I_DST_BASE;
            rot_q <= I_DIRECTION ? (2'd0 - I_DEGREES) : I_DEGREES;
            y_q   <= '0;
            x0_q  <= '0;
            xi_q  <= '0;
          end
        end
        WR_CMD: begin
          if (I_DMA_READY) begin
            if (rot_q == 2'd0 || xi_last) begin
              xi_q <= '0;
              if (seg_last) begin
                x0_q <= '0;
                y_q  <= y_q + DIM_W'(1);
              end else begin
                x0_q <= x0_q + DIM_W'(seg_n);
              end
            end else begin
              xi_q <= xi_q + DIM_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rot_addr_gen.md
ROT_ADDR_GEN -- requirements
Module: rot_addr_gen

Interface
REQ-001 SHALL have parameters: ADDR_W, 32, address width; DIM_W, 16, image dimension width; BPP_LOG2, 2, log2 bytes per pixel; BURST_MAX, 16, max beats per burst (power of two, >=2); LEN_W = log2(BURST_MAX)+1, derived.
REQ-002 Ports:
I_HCLK  in  1  clock, all logic on rising edge
I_HRESET_N  in  1  reset, asynchronous, active-low
I_START  in  1  start pulse, sampled only in IDLE
I_WIDTH  in  DIM_W  source width in pixels
I_HEIGHT  in  DIM_W  source height in pixels
I_DEGREES  in  2  0=0, 1=90, 2=180, 3=270 degrees
I_DIRECTION  in  1  0=clockwise, 1=counter-clockwise
I_SRC_BASE  in  ADDR_W  source byte base address
I_DST_BASE  in  ADDR_W  destination byte base address
I_DMA_READY  in  1  DMA accepts current command
O_VALID  out  1  command valid
O_ADDR  out  ADDR_W  command byte address
O_LEN  out  LEN_W  beats in command (1..BURST_MAX)
O_SIZE  out  3  beat size, constant BPP_LOG2
O_WRITE  out  1  0=read command, 1=write command
O_BUSY  out  1  job in progress
O_DONE  out  1  one-cycle job-complete pulse

Function
REQ-003 SHALL latch WIDTH, HEIGHT, SRC_BASE, DST_BASE and effective rotation R on I_START in IDLE; R = DEGREES when DIRECTION=0, (4-DEGREES) mod 4 when DIRECTION=1; input changes during a job SHALL be ignored.
REQ-004 SHALL implement states IDLE, RD_CMD, WR_CMD, DONE; IDLE->RD_CMD on START with W>0 and H>0; IDLE->DONE on START with W=0 or H=0 (no commands issued).
REQ-005 SHALL traverse source row-major (y outer, x inner) in segments: segment starts x0=0,BURST_MAX,2*BURST_MAX...; n = min(BURST_MAX, W-x0); segments never cross rows.
REQ-006 RD_CMD: one read, O_ADDR = SRC_BASE + ((y*W + x0) << BPP_LOG2), O_LEN = n, O_WRITE=0; on accept -> WR_CMD.
REQ-007 WR_CMD with R=0: one write burst, O_ADDR = DST_BASE + ((y*W + x0) << BPP_LOG2), O_LEN = n.
REQ-008 WR_CMD with R!=0: n single-beat writes (O_LEN=1) for x = x0..x0+n-1 in ascending order, O_ADDR = DST_BASE + ((y'*DW + x') << BPP_LOG2).
REQ-009 Transforms: R=1: x'=H-1-y, y'=x, DW=H; R=2: x'=W-1-x, y'=H-1-y, DW=W; R=3: x'=y, y'=W-1-x, DW=H.
REQ-010 After last write of a segment: next segment -> RD_CMD; after last segment of last row -> DONE.
REQ-011 Command accepted on a rising edge where O_VALID=1 and I_DMA_READY=1; while O_VALID=1 and not accepted, O_ADDR/O_LEN/O_WRITE SHALL hold stable; next command SHALL present in the cycle after acceptance (one command per cycle at READY=1, no bubbles).
REQ-012 O_VALID=1 exactly in RD_CMD and WR_CMD; O_BUSY=1 in RD_CMD, WR_CMD, DONE; O_DONE=1 only in DONE, which lasts one cycle then -> IDLE.
REQ-013 I_START during non-IDLE states SHALL be ignored.
REQ-014 Address arithmetic SHALL be unsigned, computed at full product width then truncated modulo 2^ADDR_W.
REQ-015 O_SIZE SHALL equal BPP_LOG2 at all times.

Reset
REQ-016 I_HRESET_N low SHALL immediately force IDLE and O_VALID=0, O_BUSY=0, O_DONE=0, O_WRITE=0, O_ADDR=0, O_LEN=0, all counters 0, including mid-job; no command SHALL resume after release.
REQ-017 First START SHALL be honoured on the first rising edge after reset release.

Verification
REQ-018 W=8,H=8,R=0,SRC=0x1000,DST=0x2000,READY=1 -> 16 commands alternating read/write, row y at 0x1000+32y and 0x2000+32y, LEN=8; O_DONE 1 cycle after last accept.
REQ-019 W=4,H=2,DEG=1,DIR=0,SRC=0,DST=0x100 -> read 0x0 LEN 4; writes 0x104,0x10C,0x114,0x11C; then read 0x10, writes 0x100,0x108,0x110,0x118.
REQ-020 W=4,H=2,DEG=1,DIR=1 -> first writes 0x118,0x110,0x108,0x100 (identical to DEG=3,DIR=0).
REQ-021 W=20,H=1,R=0,BURST_MAX=16,SRC=0 -> read 0x0 LEN16, write LEN16, read 0x40 LEN4, write LEN4.
REQ-022 READY low 3 cycles with O_VALID=1 -> ADDR/LEN/WRITE unchanged; START pulsed while busy -> no effect; W=0 START -> O_DONE next cycle, O_VALID never 1.
REQ-023 Reset asserted mid-job -> outputs zero same cycle; after release, idle until new START.
